// File: rtl/ie_interrupt_sequencer_pkg.sv
// Shared definitions for the interrupt sequencer: vectors, stack page,
// processor status bit positions and the sequencer state/path encodings.
package ie_defs;

    // Vector base addresses (low byte; high byte lives at +1)
    localparam logic [15:0] VEC_NMI   = 16'hFFFA;
    localparam logic [15:0] VEC_RESET = 16'hFFFC;
    localparam logic [15:0] VEC_BRK   = 16'hFFFE;

    // Hardware stack lives in page one
    localparam logic [7:0] STACK_PAGE = 8'h01;

    // Processor status bit indices
    localparam int P_C = 0;
    localparam int P_Z = 1;
    localparam int P_I = 2;
    localparam int P_D = 3;
    localparam int P_B = 4;
    localparam int P_U = 5;
    localparam int P_V = 6;
    localparam int P_N = 7;

    localparam logic [7:0] MASK_I = 8'h01 << P_I;
    localparam logic [7:0] MASK_B = 8'h01 << P_B;
    localparam logic [7:0] MASK_U = 8'h01 << P_U;

    // Sequencer states; every memory read is followed by a wait state
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PUSH_PCH,
        ST_PUSH_PCL,
        ST_PUSH_P,
        ST_VEC_LO,
        ST_VEC_LO_WAIT,
        ST_VEC_HI,
        ST_VEC_HI_WAIT,
        ST_PULL_P,
        ST_PULL_P_WAIT,
        ST_PULL_PCL,
        ST_PULL_PCL_WAIT,
        ST_PULL_PCH,
        ST_PULL_PCH_WAIT,
        ST_DONE
    } ie_state_t;

    // Which sequence was chosen at start
    typedef enum logic [2:0] {
        SEQ_NONE,
        SEQ_RESET,
        SEQ_BRK,
        SEQ_RTI,
        SEQ_NMI
    } ie_seq_t;

    // Full 16-bit stack address for a given stack pointer
    function automatic logic [15:0] stack_addr(input logic [7:0] sp);
        return {STACK_PAGE, sp};
    endfunction

endpackage

// File: rtl/ie_interrupt_sequencer.sv
// 6502-style interrupt entry/exit sequencer. Runs once per instruction after
// interrupt_start and performs soft reset, BRK, RTI, NMI or a pass-through,
// driving the memory bus while busy and returning new PC, P and SP.
module ie_interrupt_sequencer
    import ie_defs::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] interrupt_addr,
    input  logic [7:0]  mem_data_in,
    output logic [7:0]  interrupt_data_out,
    output logic        interrupt_write_en,
    input  logic        is_break,
    input  logic [7:0]  ppu_status,
    input  logic        soft_reset,
    input  logic        is_rti,
    input  logic        interrupt_start,
    output logic        interrupt_done,
    output logic        interrupt_busy,
    input  logic [15:0] pc_next,
    input  logic [7:0]  ie_status,
    input  logic [7:0]  stack_ptr,
    output logic [15:0] interrupt_pc_out,
    output logic [7:0]  interrupt_status_out,
    output logic [7:0]  interrupt_stack_out,
    output logic        interrupt_disable,
    input  logic        halt
);

    // State and working registers
    ie_state_t   r_state;
    ie_seq_t     r_seq;
    logic [15:0] r_pc;
    logic [7:0]  r_p;
    logic [7:0]  r_p_cap;
    logic [7:0]  r_sp;
    logic [15:0] r_vec;

    // Registered bus and result outputs
    logic [15:0] r_addr;
    logic [7:0]  r_wdata;
    logic        r_we;
    logic        r_done;
    logic        r_busy;
    logic [15:0] r_pc_out;
    logic [7:0]  r_status_out;
    logic [7:0]  r_stack_out;

    // Pending event latches
    logic        r_nmi_pending;
    logic        r_reset_pending;
    logic        r_vblank_prev;

    // Next-state values
    ie_state_t   w_state_next;
    ie_seq_t     w_seq_next;
    logic [15:0] w_pc_next;
    logic [7:0]  w_p_next;
    logic [7:0]  w_p_cap_next;
    logic [7:0]  w_sp_next;
    logic [15:0] w_vec_next;
    logic [15:0] w_addr_next;
    logic [7:0]  w_wdata_next;
    logic        w_we_next;
    logic        w_done_next;
    logic        w_busy_next;
    logic [15:0] w_pc_out_next;
    logic [7:0]  w_status_out_next;
    logic [7:0]  w_stack_out_next;
    logic        w_nmi_clr;
    logic        w_reset_clr;

    logic [7:0]  w_sp_inc;
    logic [7:0]  w_sp_dec;
    logic        w_vblank_rise;
    logic        w_unused_ppu;

    assign w_sp_inc      = r_sp + 8'd1;
    assign w_sp_dec      = r_sp - 8'd1;
    assign w_vblank_rise = ppu_status[P_N] & ~r_vblank_prev;
    // Only the vblank flag of the PPU status matters here
    assign w_unused_ppu  = ^ppu_status[6:0];

    assign interrupt_addr       = r_addr;
    assign interrupt_data_out   = r_wdata;
    assign interrupt_write_en   = r_we;
    assign interrupt_done       = r_done;
    assign interrupt_busy       = r_busy;
    assign interrupt_pc_out     = r_pc_out;
    assign interrupt_status_out = r_status_out;
    assign interrupt_stack_out  = r_stack_out;
    assign interrupt_disable    = r_status_out[P_I];

    // State register; halt freezes the sequence in place
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else if (!halt) begin
            r_state <= w_state_next;
        end
    end

    // Next-state and datapath decode for the sequence
    always_comb begin
        w_state_next      = r_state;
        w_seq_next        = r_seq;
        w_pc_next         = r_pc;
        w_p_next          = r_p;
        w_p_cap_next      = r_p_cap;
        w_sp_next         = r_sp;
        w_vec_next        = r_vec;
        w_addr_next       = r_addr;
        w_wdata_next      = r_wdata;
        w_we_next         = 1'b0;
        w_done_next       = r_done;
        w_busy_next       = r_busy;
        w_pc_out_next     = r_pc_out;
        w_status_out_next = r_status_out;
        w_stack_out_next  = r_stack_out;
        w_nmi_clr         = 1'b0;
        w_reset_clr       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (interrupt_start) begin
                    w_pc_next    = pc_next;
                    w_p_next     = ie_status;
                    w_p_cap_next = ie_status;
                    w_sp_next    = stack_ptr;
                    w_done_next  = 1'b0;
                    if (r_reset_pending) begin
                        // Soft reset skips the pushes but still moves SP by three
                        w_seq_next   = SEQ_RESET;
                        w_sp_next    = stack_ptr - 8'd3;
                        w_p_next     = ie_status | MASK_I;
                        w_vec_next   = VEC_RESET;
                        w_reset_clr  = 1'b1;
                        w_busy_next  = 1'b1;
                        w_state_next = ST_VEC_LO;
                    end else if (is_break) begin
                        w_seq_next   = SEQ_BRK;
                        w_vec_next   = VEC_BRK;
                        w_busy_next  = 1'b1;
                        w_state_next = ST_PUSH_PCH;
                    end else if (is_rti) begin
                        // A pending NMI is left alone and taken on the next start
                        w_seq_next   = SEQ_RTI;
                        w_busy_next  = 1'b1;
                        w_state_next = ST_PULL_P;
                    end else if (r_nmi_pending) begin
                        w_seq_next   = SEQ_NMI;
                        w_vec_next   = VEC_NMI;
                        w_nmi_clr    = 1'b1;
                        w_busy_next  = 1'b1;
                        w_state_next = ST_PUSH_PCH;
                    end else begin
                        w_seq_next   = SEQ_NONE;
                        w_state_next = ST_DONE;
                    end
                end
            end

            ST_PUSH_PCH: begin
                w_addr_next  = stack_addr(r_sp);
                w_wdata_next = r_pc[15:8];
                w_we_next    = 1'b1;
                w_sp_next    = w_sp_dec;
                w_state_next = ST_PUSH_PCL;
            end

            ST_PUSH_PCL: begin
                w_addr_next  = stack_addr(r_sp);
                w_wdata_next = r_pc[7:0];
                w_we_next    = 1'b1;
                w_sp_next    = w_sp_dec;
                w_state_next = ST_PUSH_P;
            end

            ST_PUSH_P: begin
                // B is only set in the pushed copy for BRK; U is always set
                w_addr_next  = stack_addr(r_sp);
                w_wdata_next = (r_p & ~MASK_B) | MASK_U
                             | ((r_seq == SEQ_BRK) ? MASK_B : 8'h00);
                w_we_next    = 1'b1;
                w_sp_next    = w_sp_dec;
                w_p_next     = r_p | MASK_I;
                w_state_next = ST_VEC_LO;
            end

            ST_VEC_LO: begin
                w_addr_next  = r_vec;
                w_state_next = ST_VEC_LO_WAIT;
            end

            ST_VEC_LO_WAIT: begin
                w_state_next = ST_VEC_HI;
            end

            ST_VEC_HI: begin
                w_pc_next[7:0] = mem_data_in;
                w_addr_next    = r_vec + 16'd1;
                w_state_next   = ST_VEC_HI_WAIT;
            end

            ST_VEC_HI_WAIT: begin
                w_state_next = ST_DONE;
            end

            ST_PULL_P: begin
                w_sp_next    = w_sp_inc;
                w_addr_next  = stack_addr(w_sp_inc);
                w_state_next = ST_PULL_P_WAIT;
            end

            ST_PULL_P_WAIT: begin
                w_state_next = ST_PULL_PCL;
            end

            ST_PULL_PCL: begin
                // B and U are not real flags; keep the captured copies
                w_p_next     = (mem_data_in & ~(MASK_B | MASK_U))
                             | (r_p_cap & (MASK_B | MASK_U));
                w_sp_next    = w_sp_inc;
                w_addr_next  = stack_addr(w_sp_inc);
                w_state_next = ST_PULL_PCL_WAIT;
            end

            ST_PULL_PCL_WAIT: begin
                w_state_next = ST_PULL_PCH;
            end

            ST_PULL_PCH: begin
                w_pc_next[7:0] = mem_data_in;
                w_sp_next      = w_sp_inc;
                w_addr_next    = stack_addr(w_sp_inc);
                w_state_next   = ST_PULL_PCH_WAIT;
            end

            ST_PULL_PCH_WAIT: begin
                w_state_next = ST_DONE;
            end

            ST_DONE: begin
                // Every sequenced path ends with the PC high byte arriving now
                w_pc_out_next     = (r_seq == SEQ_NONE) ? r_pc
                                                        : {mem_data_in, r_pc[7:0]};
                w_status_out_next = r_p;
                w_stack_out_next  = r_sp;
                w_done_next       = 1'b1;
                w_busy_next       = 1'b0;
                w_state_next      = ST_IDLE;
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Working registers, bus outputs and results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seq        <= SEQ_NONE;
            r_pc         <= 16'h0000;
            r_p          <= 8'h00;
            r_p_cap      <= 8'h00;
            r_sp         <= 8'h00;
            r_vec        <= 16'h0000;
            r_addr       <= 16'h0000;
            r_wdata      <= 8'h00;
            r_we         <= 1'b0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
            r_pc_out     <= 16'h0000;
            r_status_out <= 8'h00;
            r_stack_out  <= 8'hFF;
        end else if (!halt) begin
            r_seq        <= w_seq_next;
            r_pc         <= w_pc_next;
            r_p          <= w_p_next;
            r_p_cap      <= w_p_cap_next;
            r_sp         <= w_sp_next;
            r_vec        <= w_vec_next;
            r_addr       <= w_addr_next;
            r_wdata      <= w_wdata_next;
            r_we         <= w_we_next;
            r_done       <= w_done_next;
            r_busy       <= w_busy_next;
            r_pc_out     <= w_pc_out_next;
            r_status_out <= w_status_out_next;
            r_stack_out  <= w_stack_out_next;
        end
    end

    // Event latches: a new event wins over a same-cycle clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vblank_prev   <= 1'b0;
            r_nmi_pending   <= 1'b0;
            r_reset_pending <= 1'b0;
        end else if (!halt) begin
            r_vblank_prev <= ppu_status[P_N];
            if (w_vblank_rise) begin
                r_nmi_pending <= 1'b1;
            end else if (w_nmi_clr) begin
                r_nmi_pending <= 1'b0;
            end
            if (soft_reset) begin
                r_reset_pending <= 1'b1;
            end else if (w_reset_clr) begin
                r_reset_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ie_interrupt_sequencer.sv
// Directed bench for the interrupt sequencer with a small registered-read memory.
module tb_ie_interrupt_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] interrupt_addr;
    logic [7:0]  mem_data_in;
    logic [7:0]  interrupt_data_out;
    logic        interrupt_write_en;
    logic        is_break;
    logic [7:0]  ppu_status;
    logic        soft_reset;
    logic        is_rti;
    logic        interrupt_start;
    logic        interrupt_done;
    logic        interrupt_busy;
    logic [15:0] pc_next;
    logic [7:0]  ie_status;
    logic [7:0]  stack_ptr;
    logic [15:0] interrupt_pc_out;
    logic [7:0]  interrupt_status_out;
    logic [7:0]  interrupt_stack_out;
    logic        interrupt_disable;
    logic        halt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ie_interrupt_sequencer dut (
        .clk                  (clk),
        .rst                  (rst),
        .interrupt_addr       (interrupt_addr),
        .mem_data_in          (mem_data_in),
        .interrupt_data_out   (interrupt_data_out),
        .interrupt_write_en   (interrupt_write_en),
        .is_break             (is_break),
        .ppu_status           (ppu_status),
        .soft_reset           (soft_reset),
        .is_rti               (is_rti),
        .interrupt_start      (interrupt_start),
        .interrupt_done       (interrupt_done),
        .interrupt_busy       (interrupt_busy),
        .pc_next              (pc_next),
        .ie_status            (ie_status),
        .stack_ptr            (stack_ptr),
        .interrupt_pc_out     (interrupt_pc_out),
        .interrupt_status_out (interrupt_status_out),
        .interrupt_stack_out  (interrupt_stack_out),
        .interrupt_disable    (interrupt_disable),
        .halt                 (halt)
    );

    // Memory: address seen at edge k is returned after edge k+1
    logic [7:0]  mem [0:65535];
    logic [7:0]  mem_rdata = 8'h00;
    logic        poke_en = 1'b0;
    logic [15:0] poke_addr = 16'h0000;
    logic [7:0]  poke_data = 8'h00;
    logic [15:0] wr_addr_q[$];
    logic [7:0]  wr_data_q[$];
    int          busy_cnt = 0;

    assign mem_data_in = mem_rdata;

    always @(posedge clk) begin
        mem_rdata <= mem[interrupt_addr];
        if (poke_en) begin
            mem[poke_addr] <= poke_data;
        end else if (interrupt_write_en && !halt && !rst) begin
            mem[interrupt_addr] <= interrupt_data_out;
            wr_addr_q.push_back(interrupt_addr);
            wr_data_q.push_back(interrupt_data_out);
        end
        if (interrupt_busy && !halt) busy_cnt <= busy_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        poke_en   = 1'b1;
        poke_addr = a;
        poke_data = d;
        tick();
        poke_en   = 1'b0;
    endtask

    task automatic start_seq(input logic [15:0] pc, input logic [7:0] p, input logic [7:0] sp,
                             input logic brk, input logic rti);
        pc_next         = pc;
        ie_status       = p;
        stack_ptr       = sp;
        is_break        = brk;
        is_rti          = rti;
        interrupt_start = 1'b1;
        tick();
        interrupt_start = 1'b0;
        is_break        = 1'b0;
        is_rti          = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int cycles);
        cycles = 1;
        while (!interrupt_done && cycles < 40) begin
            tick();
            cycles++;
        end
        check({tag, " done"}, interrupt_done, 1'b1);
        check({tag, " busy_at_done"}, interrupt_busy, 1'b0);
    endtask

    task automatic check_result(input string tag, input logic [15:0] pc, input logic [7:0] p,
                                input logic [7:0] sp);
        check({tag, " pc"}, interrupt_pc_out, pc);
        check({tag, " status"}, interrupt_status_out, p);
        check({tag, " stack"}, interrupt_stack_out, sp);
        check({tag, " disable"}, interrupt_disable, p[2]);
        $display("%s: pc=%h p=%h sp=%h", tag, interrupt_pc_out, interrupt_status_out,
                 interrupt_stack_out);
    endtask

    initial begin
        int n;
        int wbase;
        int bbase;

        rst = 1'b1; halt = 1'b0; is_break = 1'b0; is_rti = 1'b0; soft_reset = 1'b0;
        interrupt_start = 1'b0; ppu_status = 8'h00; pc_next = 16'h0000;
        ie_status = 8'h00; stack_ptr = 8'h00;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Reset values
        check("rst addr", interrupt_addr, 16'h0000);
        check("rst wdata", interrupt_data_out, 8'h00);
        check("rst we", interrupt_write_en, 1'b0);
        check("rst done", interrupt_done, 1'b0);
        check("rst busy", interrupt_busy, 1'b0);
        check("rst pc", interrupt_pc_out, 16'h0000);
        check("rst status", interrupt_status_out, 8'h00);
        check("rst stack", interrupt_stack_out, 8'hFF);
        check("rst disable", interrupt_disable, 1'b0);

        // Vectors
        poke(16'hFFFE, 8'h34); poke(16'hFFFF, 8'h12);
        poke(16'hFFFA, 8'h00); poke(16'hFFFB, 8'hA0);
        poke(16'hFFFC, 8'h00); poke(16'hFFFD, 8'h80);

        // Pass-through
        wbase = wr_addr_q.size(); bbase = busy_cnt;
        start_seq(16'h8123, 8'h24, 8'hFD, 1'b0, 1'b0);
        wait_done("pass", n);
        check("pass latency<=2", (n <= 2), 1'b1);
        check("pass writes", wr_addr_q.size() - wbase, 0);
        check("pass busy cycles", busy_cnt - bbase, 0);
        check_result("pass", 16'h8123, 8'h24, 8'hFD);

        // BRK
        wbase = wr_addr_q.size(); bbase = busy_cnt;
        start_seq(16'hC002, 8'h00, 8'hFD, 1'b1, 1'b0);
        check("brk done cleared", interrupt_done, 1'b0);
        check("brk busy", interrupt_busy, 1'b1);
        wait_done("brk", n);
        check("brk writes", wr_addr_q.size() - wbase, 3);
        check("brk w0 addr", wr_addr_q[wbase], 16'h01FD);
        check("brk w0 data", wr_data_q[wbase], 8'hC0);
        check("brk w1 addr", wr_addr_q[wbase+1], 16'h01FC);
        check("brk w1 data", wr_data_q[wbase+1], 8'h02);
        check("brk w2 addr", wr_addr_q[wbase+2], 16'h01FB);
        check("brk w2 data", wr_data_q[wbase+2], 8'h30);
        check("brk busy seen", (busy_cnt - bbase) > 0, 1'b1);
        check_result("brk", 16'h1234, 8'h04, 8'hFA);

        // RTI: captured P 24 supplies bits 4/5 (=10 binary) -> C3 becomes E3
        poke(16'h01FB, 8'hC3);
        wbase = wr_addr_q.size();
        start_seq(16'h5555, 8'h24, 8'hFA, 1'b0, 1'b1);
        wait_done("rti", n);
        check("rti writes", wr_addr_q.size() - wbase, 0);
        check_result("rti", 16'hC002, 8'hE3, 8'hFD);

        // NMI on vblank rising edge
        ppu_status = 8'h00; tick();
        ppu_status = 8'h80; tick();
        wbase = wr_addr_q.size();
        start_seq(16'h9000, 8'h01, 8'hFF, 1'b0, 1'b0);
        check("nmi busy", interrupt_busy, 1'b1);
        wait_done("nmi", n);
        check("nmi writes", wr_addr_q.size() - wbase, 3);
        check("nmi w0 addr", wr_addr_q[wbase], 16'h01FF);
        check("nmi w0 data", wr_data_q[wbase], 8'h90);
        check("nmi w1 addr", wr_addr_q[wbase+1], 16'h01FE);
        check("nmi w1 data", wr_data_q[wbase+1], 8'h00);
        check("nmi w2 addr", wr_addr_q[wbase+2], 16'h01FD);
        check("nmi w2 data", wr_data_q[wbase+2], 8'h21);
        check_result("nmi", 16'hA000, 8'h05, 8'hFC);

        // Level stays high: no new edge, so this is a pass-through
        wbase = wr_addr_q.size(); bbase = busy_cnt;
        start_seq(16'h4567, 8'h05, 8'hFC, 1'b0, 1'b0);
        wait_done("nmi2", n);
        check("nmi2 busy cycles", busy_cnt - bbase, 0);
        check("nmi2 writes", wr_addr_q.size() - wbase, 0);
        check_result("nmi2", 16'h4567, 8'h05, 8'hFC);

        // Soft reset outranks a simultaneous BRK
        soft_reset = 1'b1; tick(); soft_reset = 1'b0;
        wbase = wr_addr_q.size();
        start_seq(16'h7777, 8'h00, 8'hFD, 1'b1, 1'b0);
        wait_done("sreset", n);
        check("sreset writes", wr_addr_q.size() - wbase, 0);
        check_result("sreset", 16'h8000, 8'h04, 8'hFA);

        // Halt mid-BRK during the vector read, then resume
        wbase = wr_addr_q.size();
        start_seq(16'hC002, 8'h00, 8'hFD, 1'b1, 1'b0);
        tick(); tick(); tick(); tick();
        halt = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("halt addr", interrupt_addr, 16'hFFFE);
            check("halt we", interrupt_write_en, 1'b0);
            check("halt busy", interrupt_busy, 1'b1);
            check("halt done", interrupt_done, 1'b0);
        end
        halt = 1'b0;
        wait_done("halt brk", n);
        check("halt brk writes", wr_addr_q.size() - wbase, 3);
        check("halt brk w2 addr", wr_addr_q[wbase+2], 16'h01FB);
        check("halt brk w2 data", wr_data_q[wbase+2], 8'h30);
        check_result("halt brk", 16'h1234, 8'h04, 8'hFA);

        // Asynchronous reset while a push is on the bus
        wbase = wr_addr_q.size();
        start_seq(16'hC002, 8'h00, 8'hFD, 1'b1, 1'b0);
        tick();
        check("pre-rst we", interrupt_write_en, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("midrst we", interrupt_write_en, 1'b0);
        check("midrst addr", interrupt_addr, 16'h0000);
        check("midrst busy", interrupt_busy, 1'b0);
        check("midrst stack", interrupt_stack_out, 8'hFF);
        check("midrst pc", interrupt_pc_out, 16'h0000);
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("midrst writes", wr_addr_q.size() - wbase, 0);
        check("midrst idle busy", interrupt_busy, 1'b0);
        check("midrst idle done", interrupt_done, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ie_interrupt_sequencer.md
Name: ie_interrupt_sequencer

Overview:
Sequences 6502-style interrupt entry and exit for the CPU execute FSM. It runs once per instruction after the execute FSM pulses `interrupt_start`. Depending on pending events it either performs a soft reset, BRK, RTI, NMI, or a pass-through. It owns the memory bus while `interrupt_busy` is high, and returns the new PC, status and stack pointer.

Parameters:
none (vectors and status bit positions are package constants)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- interrupt_addr  out  16  memory address while busy
- mem_data_in  in  8  memory read data
- interrupt_data_out  out  8  memory write data
- interrupt_write_en  out  1  memory write strobe
- is_break  in  1  current instruction is BRK
- ppu_status  in  8  PPU status; bit 7 = vblank (NMI source)
- soft_reset  in  1  request soft reset
- is_rti  in  1  current instruction is RTI
- interrupt_start  in  1  one-cycle start pulse
- interrupt_done  out  1  results valid
- interrupt_busy  out  1  block drives memory bus
- pc_next  in  16  PC after current instruction
- ie_status  in  8  current processor status P
- stack_ptr  in  8  current stack pointer
- interrupt_pc_out  out  16  resulting PC
- interrupt_status_out  out  8  resulting P
- interrupt_stack_out  out  8  resulting SP
- interrupt_disable  out  1  equals `interrupt_status_out[2]`
- halt  in  1  freeze

Behaviour:
- Reset values: all outputs 0 except `interrupt_stack_out` = 8'hFF. `nmi_pending`, `reset_pending` and `vblank_prev` are 0. State is IDLE.
- `halt` = 1: no register (including the pending latches) changes.
- Event latching, every non-halted cycle:
  - `vblank_prev` <= `ppu_status[7]`.
  - A rising edge of `ppu_status[7]` sets `nmi_pending`.
  - `soft_reset` = 1 sets `reset_pending`.
- IDLE, on `interrupt_start`:
  - Capture `pc_next`, `ie_status` and `stack_ptr` into working registers.
  - Clear `interrupt_done`.
  - Choose a sequence by priority: reset_pending > is_break > is_rti > nmi_pending > none.
- Pass-through (none): outputs = captured values; `interrupt_done` = 1 on the next cycle; `interrupt_busy` stays 0.
- Sequenced paths: `interrupt_busy` = 1 from the cycle after start until the cycle `interrupt_done` rises, then 0.
- Stack address is {8'h01, sp}.
  - Push: register address, data and `interrupt_write_en` = 1 for exactly one cycle, then sp <= sp-1 (8-bit wrap).
  - Pull: sp <= sp+1, then address {8'h01, sp+1}.
- Read latency: an address registered at edge k has its data sampled at edge k+2. `interrupt_write_en` = 0 during reads.
- BRK:
  - Push PCH, then PCL of captured PC.
  - Push P with bits 4 and 5 set.
  - Set I (bit 2).
  - Read FFFE (low byte), then FFFF (high byte) into the PC.
- NMI:
  - Same as BRK except the pushed P has bit 4 clear and bit 5 set.
  - Vector is FFFA/FFFB.
  - Taken regardless of I.
  - Clears `nmi_pending`.
- Soft reset:
  - No writes; SP <= SP-3.
  - Set I.
  - PC from FFFC/FFFD.
  - Clears `reset_pending`.
- RTI:
  - Pull P; bits 4 and 5 are taken from the captured P, others from memory.
  - Pull PCL, then PCH.
  - `nmi_pending` stays pending and is serviced on the next start.
- DONE:
  - `interrupt_done` = 1 and outputs hold until the next `interrupt_start` is sampled (sticky level).
  - Return to IDLE.
- States: IDLE, PUSH_PCH, PUSH_PCL, PUSH_P, VEC_LO, VEC_LO_WAIT, VEC_HI, VEC_HI_WAIT, PULL_P, PULL_PCL, PULL_PCH (each pull with a wait state), DONE.
- Reset mid-sequence: abort immediately to reset values; no further writes.
- `interrupt_start` while not IDLE: ignored.

Decomposition:
- Shared package `ie_defs`: vector addresses (NMI FFFA, RESET FFFC, BRK FFFE), stack page 8'h01, status bit indices (C=0, Z=1, I=2, D=3, B=4, U=5, V=6, N=7), state enum.
- No sub-module; the vblank edge detector is inline.

Test Plan:
- Pass-through: start with `pc_next` = 8123, P = 24, SP = FD, no events → done within 2 cycles, outputs 8123/24/FD, no writes, busy stays 0.
- BRK: SP = FD, `pc_next` = C002, P = 00, mem FFFE = 34, FFFF = 12 → writes 0x01FD = C0, 0x01FC = 02, 0x01FB = 30; PC = 1234, SP = FA, P = 04, `interrupt_disable` = 1.
- NMI: `ppu_status` 00→80, then start, SP = FF, PC = 9000, P = 01, mem FFFA/FFFB = 00/A0 → pushes 90, 00, 21; PC = A000, SP = FC, P = 05. A second start without a new edge is a pass-through.
- RTI: SP = FA, mem 0x01FB = C3, 01FC = 02, 01FD = C0 → P = C3 with bits 4/5 from captured P, PC = C002, SP = FD, no writes.
- Soft reset: pulse `soft_reset`, start, SP = FD, FFFC/FFFD = 00/80 → PC = 8000, SP = FA, I set, no writes.
- Halt/reset: `halt` = 1 mid-BRK freezes all outputs for 5 cycles, then the sequence resumes identically. `rst` mid-sequence → reset values and write_en = 0 immediately.
